// File: rtl/led_frame_if.sv
`timescale 1ns/1ps
// led_frame_if
// Bundles the pixel handshake and the driver-side serial pins of the LED
// frame transmitter.
//   start      : one-cycle request to send a frame (source -> transmitter)
//   pix_valid  : pix_data holds a pixel (source -> transmitter)
//   pix_data   : 8-bit pixel value (source -> transmitter)
//   pix_ready  : transmitter takes pix_data this cycle if pix_valid is high
//   DCK/DAI/DEN: serial clock, data (LSB first) and data enable to the driver
//   Vsync      : end-of-frame sync pulse to the driver
//   busy       : frame in progress
//   frame_done : one-cycle pulse as Vsync ends
// The transmitter connects through the slave modport, the pixel source
// (frame buffer, pattern generator, bench) through the master modport.
interface led_frame_if;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       DCK;
    logic       DAI;
    logic       DEN;
    logic       Vsync;
    logic       busy;
    logic       frame_done;

    modport master (
        output start, pix_valid, pix_data,
        input  pix_ready, DCK, DAI, DEN, Vsync, busy, frame_done
    );

    modport slave (
        input  start, pix_valid, pix_data,
        output pix_ready, DCK, DAI, DEN, Vsync, busy, frame_done
    );
endinterface

// File: rtl/led_frame_tx.sv
`timescale 1ns/1ps
// led_frame_tx
// Transmit end of the DCK/DAI/DEN/Vsync link into the LED display driver.
// Takes FRAME_PIX pixels over a valid/ready handshake, shifts each one out
// LSB first with DEN high across its 8 DCK rising edges, inserts GAP_DCK idle
// DCK periods after every pixel, then raises Vsync for VSYNC_LEN clocks and
// pulses frame_done.
// Ports:
//   clk : system clock, DCK runs at clk/2 while a pixel is being shifted
//   rst : asynchronous active-high reset, aborts a frame without any Vsync
//   lnk : led_frame_if.slave (start, pixel handshake, serial pins, status)
module led_frame_tx #(
    parameter int FRAME_PIX = 512,
    parameter int GAP_DCK   = 1,
    parameter int VSYNC_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    led_frame_if.slave lnk
);
    localparam int PIX_W = $clog2(FRAME_PIX) + 1;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(2 * GAP_DCK - 1);
    localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(VSYNC_LEN - 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(FRAME_PIX - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, VSYNC, DONE} state_t;

    state_t           state_q, state_d;
    // Cycle counter inside SHIFT/GAP/VSYNC. In SHIFT, bit 0 is the DCK
    // phase and bits 3:1 are the index of the data bit being sent.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]       shreg_q, shreg_d;

    logic dck_q,   dck_d;
    logic dai_q,   dai_d;
    logic den_q,   den_d;
    logic vsync_q, vsync_d;
    logic ready_q, ready_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;

    logic fire;
    assign fire = lnk.pix_valid && ready_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (lnk.start) state_d = LOAD;
            LOAD:    if (fire) state_d = SHIFT;
            SHIFT:   if (cnt_q == SHIFT_LAST) state_d = GAP;
            GAP:     if (cnt_q == GAP_LAST) state_d = (pix_cnt_q == PIX_LAST) ? VSYNC : LOAD;
            VSYNC:   if (cnt_q == VSYNC_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values. Every output is registered from the
    // next state, so each pin settles on the same edge the state changes.
    always_comb begin
        cnt_d     = '0;
        pix_cnt_d = pix_cnt_q;
        shreg_d   = fire ? lnk.pix_data : shreg_q;
        dck_d     = 1'b0;
        dai_d     = 1'b0;
        den_d     = 1'b0;
        vsync_d   = 1'b0;
        ready_d   = 1'b0;
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = 1'b0;

        if ((state_d == state_q) &&
            ((state_q == SHIFT) || (state_q == GAP) || (state_q == VSYNC))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_q == DONE) begin
            pix_cnt_d = '0;
        end else if ((state_q == GAP) && (state_d != GAP)) begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
        end

        unique case (state_d)
            LOAD:  ready_d = 1'b1;
            SHIFT: begin
                // DAI/DEN are set while DCK is low and held through the
                // following high phase, so the receiver gets half a DCK
                // period of setup and of hold around each rising edge.
                dck_d = cnt_d[0];
                den_d = 1'b1;
                dai_d = shreg_d[cnt_d[3:1]];
            end
            GAP:   dck_d = cnt_d[0];
            VSYNC: vsync_d = 1'b1;
            DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            pix_cnt_q <= '0;
            shreg_q   <= '0;
            dck_q     <= 1'b0;
            dai_q     <= 1'b0;
            den_q     <= 1'b0;
            vsync_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pix_cnt_q <= pix_cnt_d;
            shreg_q   <= shreg_d;
            dck_q     <= dck_d;
            dai_q     <= dai_d;
            den_q     <= den_d;
            vsync_q   <= vsync_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign lnk.DCK        = dck_q;
    assign lnk.DAI        = dai_q;
    assign lnk.DEN        = den_q;
    assign lnk.Vsync      = vsync_q;
    assign lnk.pix_ready  = ready_q;
    assign lnk.busy       = busy_q;
    assign lnk.frame_done = done_q;
endmodule
